// File: rtl/terrain_pkg.sv
// Shared types for the terrain probe scheduler and its address calculator.
//   terrain_t     : 2-bit terrain codes stored in the map BRAM
//   probe_idx_t   : probe slot order within one sweep
//   TAG_EXT/NONE  : tag values for the read-tracking pipeline
//   sched_state_t : scheduler FSM states
//   tag_entry_t   : one read-tracking pipeline stage
package terrain_pkg;

    typedef enum logic [1:0] {
        HOLE  = 2'd0,
        WALL  = 2'd1,
        GRASS = 2'd2,
        SAND  = 2'd3
    } terrain_t;

    typedef enum logic [2:0] {
        CENTER = 3'd0,
        XPLUS  = 3'd1,
        YPLUS  = 3'd2,
        XMINUS = 3'd3,
        YMINUS = 3'd4
    } probe_idx_t;

    localparam int unsigned NUM_PROBES = 5;

    localparam logic [2:0] TAG_EXT  = 3'd5;
    localparam logic [2:0] TAG_NONE = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } sched_state_t;

    // off_map marks a probe slot that drove no read; its result is forced at retire.
    typedef struct packed {
        logic       off_map;
        logic [2:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/probe_addr_calc.sv
// Combinational probe address calculator.
// Maps an 8.8 fixed-point position plus a probe index to a map cell address.
//   pos_x, pos_y : 8.8 fixed-point position
//   probe        : which probe (centre or one of the four edge offsets)
//   addr         : cell_x + WIDTH * cell_y, truncated to 16 bits
//   off_map      : probe lands outside the map (borrow, carry or out of range)
module probe_addr_calc
    import terrain_pkg::*;
#(
    parameter int unsigned WIDTH        = 160,
    parameter int unsigned HEIGHT       = 90,
    parameter logic [15:0] PROBE_OFFSET = 16'h0080
) (
    input  logic [15:0] pos_x,
    input  logic [15:0] pos_y,
    input  probe_idx_t  probe,
    output logic [15:0] addr,
    output logic        off_map
);

    logic [16:0] sum_x;
    logic [16:0] sum_y;
    logic [7:0]  cell_x;
    logic [7:0]  cell_y;

    always_comb begin
        sum_x = {1'b0, pos_x};
        sum_y = {1'b0, pos_y};
        case (probe)
            XPLUS:   sum_x = {1'b0, pos_x} + {1'b0, PROBE_OFFSET};
            YPLUS:   sum_y = {1'b0, pos_y} + {1'b0, PROBE_OFFSET};
            XMINUS:  sum_x = {1'b0, pos_x} - {1'b0, PROBE_OFFSET};
            YMINUS:  sum_y = {1'b0, pos_y} - {1'b0, PROBE_OFFSET};
            default: ;
        endcase
    end

    assign cell_x = sum_x[15:8];
    assign cell_y = sum_y[15:8];

    // Bit 16 is set both by a carry out of the add and a borrow out of the subtract.
    assign off_map = sum_x[16] | sum_y[16] |
                     (32'(cell_x) >= WIDTH) | (32'(cell_y) >= HEIGHT);

    assign addr = 16'(32'(cell_x) + WIDTH * 32'(cell_y));

endmodule

// File: rtl/terrain_probe_scheduler.sv
// Shares one single-port map BRAM between a five-probe collision sweep and an
// external reader.
//   clk_in, rst_in            : clock, asynchronous active-high reset
//   start                     : begin a sweep (one deep queue if busy)
//   ball_position_x/_y        : 8.8 position, sampled on the sweep-start cycle
//   map_addr / map_data       : BRAM address out, data back READ_LATENCY later
//   ext_req/ext_addr/ext_gnt  : external read request, granted outside ISSUE
//   ext_rsp_valid/_data       : external read response
//   terrain_*                 : results of the last completed sweep
//   probes_valid              : one-cycle pulse when terrain_* update
//   busy                      : sweep in progress (through the valid cycle)
module terrain_probe_scheduler
    import terrain_pkg::*;
#(
    parameter int unsigned WIDTH        = 160,
    parameter int unsigned HEIGHT       = 90,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] PROBE_OFFSET = 16'h0080,
    parameter logic [1:0]  OOB_CODE     = 2'd1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [15:0] ball_position_x,
    input  logic [15:0] ball_position_y,
    output logic [15:0] map_addr,
    input  logic [1:0]  map_data,
    input  logic        ext_req,
    input  logic [15:0] ext_addr,
    output logic        ext_gnt,
    output logic        ext_rsp_valid,
    output logic [1:0]  ext_rsp_data,
    output logic [1:0]  terrain_center,
    output logic [1:0]  terrain_xplus,
    output logic [1:0]  terrain_yplus,
    output logic [1:0]  terrain_xminus,
    output logic [1:0]  terrain_yminus,
    output logic        probes_valid,
    output logic        busy
);

    sched_state_t state_q, state_d;
    probe_idx_t   slot_q, slot_d;
    logic         pending_q, pending_d;
    logic         latch_pos;
    logic         issuing;
    logic         probe_in_flight;
    logic [15:0]  pos_x_q, pos_y_q;
    logic [15:0]  map_addr_q;
    logic [1:0]   ext_rsp_q;
    logic [15:0]  probe_addr;
    logic         probe_off_map;
    tag_entry_t   issue_entry;
    tag_entry_t   tail;
    tag_entry_t   pipe_q   [READ_LATENCY];
    logic [1:0]   result_q [NUM_PROBES];
    logic [1:0]   terrain_q[NUM_PROBES];

    probe_addr_calc #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .PROBE_OFFSET(PROBE_OFFSET)
    ) u_addr_calc (
        .pos_x  (pos_x_q),
        .pos_y  (pos_y_q),
        .probe  (slot_q),
        .addr   (probe_addr),
        .off_map(probe_off_map)
    );

    // Any probe still ahead of the tail stage keeps the sweep in DRAIN.
    always_comb begin
        probe_in_flight = 1'b0;
        for (int unsigned i = 0; i + 1 < READ_LATENCY; i++) begin
            if (pipe_q[i].tag < TAG_EXT) probe_in_flight = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pending_d = pending_q;
        latch_pos = 1'b0;
        issuing   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    latch_pos = 1'b1;
                    slot_d    = CENTER;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                issuing = 1'b1;
                if (start) pending_d = 1'b1;
                if (slot_q == YMINUS) state_d = StDrain;
                else                  slot_d  = probe_idx_t'(slot_q + 3'd1);
            end
            StDrain: begin
                if (start) pending_d = 1'b1;
                if (!probe_in_flight) state_d = StDone;
            end
            StDone: begin
                // A start arriving in the DONE cycle chains straight into the next sweep.
                if (pending_q || start) begin
                    latch_pos = 1'b1;
                    pending_d = 1'b0;
                    slot_d    = CENTER;
                    state_d   = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by reset so every output reads zero while reset is held.
    assign ext_gnt = ext_req & ~issuing & ~rst_in;

    always_comb begin
        map_addr    = map_addr_q;
        issue_entry = '{off_map: 1'b0, tag: TAG_NONE};
        if (issuing) begin
            issue_entry = '{off_map: probe_off_map, tag: 3'(slot_q)};
            if (!probe_off_map) map_addr = probe_addr;
        end else if (ext_gnt) begin
            issue_entry = '{off_map: 1'b0, tag: TAG_EXT};
            map_addr    = ext_addr;
        end
    end

    assign tail          = pipe_q[READ_LATENCY-1];
    assign ext_rsp_valid = (tail.tag == TAG_EXT);
    assign ext_rsp_data  = ext_rsp_valid ? map_data : ext_rsp_q;
    assign probes_valid  = (state_q == StDone);
    assign busy          = (state_q != StIdle);

    // In the DONE cycle the fresh results are shown directly, then held from terrain_q.
    assign terrain_center = probes_valid ? result_q[0] : terrain_q[0];
    assign terrain_xplus  = probes_valid ? result_q[1] : terrain_q[1];
    assign terrain_yplus  = probes_valid ? result_q[2] : terrain_q[2];
    assign terrain_xminus = probes_valid ? result_q[3] : terrain_q[3];
    assign terrain_yminus = probes_valid ? result_q[4] : terrain_q[4];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            slot_q     <= CENTER;
            pending_q  <= 1'b0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            map_addr_q <= '0;
            ext_rsp_q  <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '{off_map: 1'b0, tag: TAG_NONE};
            end
            for (int unsigned i = 0; i < NUM_PROBES; i++) begin
                result_q[i]  <= '0;
                terrain_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            pending_q  <= pending_d;
            map_addr_q <= map_addr;
            if (latch_pos) begin
                pos_x_q <= ball_position_x;
                pos_y_q <= ball_position_y;
            end
            pipe_q[0] <= issue_entry;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (tail.tag < TAG_EXT) begin
                result_q[tail.tag] <= tail.off_map ? OOB_CODE : map_data;
            end
            if (tail.tag == TAG_EXT) ext_rsp_q <= map_data;
            if (state_q == StDone) begin
                for (int unsigned i = 0; i < NUM_PROBES; i++) begin
                    terrain_q[i] <= result_q[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_terrain_probe_scheduler.sv
module tb_terrain_probe_scheduler;

    localparam int         WIDTH  = 160;
    localparam int         HEIGHT = 90;
    localparam int         RL     = 2;
    localparam int         OFF    = 128;
    localparam logic [1:0] OOB    = 2'd1;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ball_position_x = '0;
    logic [15:0] ball_position_y = '0;
    logic [15:0] map_addr;
    logic [1:0]  map_data;
    logic        ext_req = 1'b0;
    logic [15:0] ext_addr = '0;
    logic        ext_gnt, ext_rsp_valid, probes_valid, busy;
    logic [1:0]  ext_rsp_data;
    logic [1:0]  t_c, t_xp, t_yp, t_xm, t_ym;

    terrain_probe_scheduler dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start          (start),
        .ball_position_x(ball_position_x),
        .ball_position_y(ball_position_y),
        .map_addr       (map_addr),
        .map_data       (map_data),
        .ext_req        (ext_req),
        .ext_addr       (ext_addr),
        .ext_gnt        (ext_gnt),
        .ext_rsp_valid  (ext_rsp_valid),
        .ext_rsp_data   (ext_rsp_data),
        .terrain_center (t_c),
        .terrain_xplus  (t_xp),
        .terrain_yplus  (t_yp),
        .terrain_xminus (t_xm),
        .terrain_yminus (t_ym),
        .probes_valid   (probes_valid),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    // Map BRAM with a fixed address-to-data latency.
    logic [1:0] mem [65536];
    logic [1:0] rd_pipe [RL];
    always @(posedge clk_in) begin
        rd_pipe[0] <= mem[map_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign map_data = rd_pipe[RL-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: sweep windows in absolute cycles, results from plain arithmetic.
    int          issue_start, done_cyc, lat_x, lat_y;
    bit          pending;
    logic [15:0] last_addr;
    logic [1:0]  last_rsp;
    logic [1:0]  sweep_res [5];
    logic [1:0]  exp_terr  [5];
    int          rsp_cyc [$];
    logic [1:0]  rsp_dat [$];
    int          pv_count, last_pv;
    bit          last_gnt;
    bit          gnt_log [int];

    function automatic void probe_ref(input int px, input int py, input int j,
                                      output int addr, output bit oob);
        int x = px;
        int y = py;
        case (j)
            1: x = x + OFF;
            2: y = y + OFF;
            3: x = x - OFF;
            4: y = y - OFF;
            default: ;
        endcase
        oob  = (x < 0) || (y < 0) || (x > 65535) || (y > 65535) ||
               (x / 256 >= WIDTH) || (y / 256 >= HEIGHT);
        addr = oob ? 0 : ((x / 256) + WIDTH * (y / 256)) % 65536;
    endfunction

    task automatic model_reset();
        issue_start = -100;
        done_cyc    = -100;
        pending     = 0;
        last_addr   = '0;
        last_rsp    = '0;
        for (int i = 0; i < 5; i++) begin
            sweep_res[i] = '0;
            exp_terr[i]  = '0;
        end
        rsp_cyc.delete();
        rsp_dat.delete();
        last_gnt = 0;
    endtask

    task automatic model_cycle();
        bit          active, in_issue, gnt, oob, exp_rv;
        int          addr;
        logic [15:0] exp_addr;
        logic [1:0]  exp_rsp;
        active   = (cyc >= issue_start) && (cyc <= done_cyc);
        in_issue = (cyc >= issue_start) && (cyc <= issue_start + 4);
        gnt      = ext_req && !in_issue;
        if (cyc == done_cyc) exp_terr = sweep_res;
        exp_addr = last_addr;
        if (in_issue) begin
            probe_ref(lat_x, lat_y, cyc - issue_start, addr, oob);
            if (oob) sweep_res[cyc - issue_start] = OOB;
            else begin
                exp_addr = 16'(addr);
                sweep_res[cyc - issue_start] = mem[addr];
            end
        end else if (gnt) begin
            exp_addr = ext_addr;
            rsp_cyc.push_back(cyc + RL);
            rsp_dat.push_back(mem[ext_addr]);
        end
        exp_rv  = 0;
        exp_rsp = last_rsp;
        if (rsp_cyc.size() > 0 && rsp_cyc[0] == cyc) begin
            exp_rv   = 1;
            exp_rsp  = rsp_dat[0];
            last_rsp = exp_rsp;
            void'(rsp_cyc.pop_front());
            void'(rsp_dat.pop_front());
        end
        check("busy", 32'(busy), 32'(active));
        check("probes_valid", 32'(probes_valid), 32'(cyc == done_cyc));
        check("ext_gnt", 32'(ext_gnt), 32'(gnt));
        check("map_addr", 32'(map_addr), 32'(exp_addr));
        check("ext_rsp_valid", 32'(ext_rsp_valid), 32'(exp_rv));
        check("ext_rsp_data", 32'(ext_rsp_data), 32'(exp_rsp));
        check("terrain", {22'd0, t_c, t_xp, t_yp, t_xm, t_ym},
              {22'd0, exp_terr[0], exp_terr[1], exp_terr[2], exp_terr[3], exp_terr[4]});
        if (probes_valid) begin
            pv_count++;
            last_pv = cyc;
        end
        last_gnt     = ext_gnt;
        gnt_log[cyc] = ext_gnt;
        last_addr    = exp_addr;
        if ((cyc == done_cyc && (pending || start)) || (start && !active)) begin
            issue_start = cyc + 1;
            done_cyc    = cyc + 5 + RL + 1;
            lat_x       = int'(ball_position_x);
            lat_y       = int'(ball_position_y);
            pending     = 0;
        end else if (start) begin
            pending = 1;
        end
    endtask

    task automatic step();
        #1;
        model_cycle();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"},
              {map_addr, 2'b0, t_c, t_xp, t_yp, t_xm, t_ym},
              32'd0);
        check({tag, "_strobes"},
              {26'd0, probes_valid, busy, ext_gnt, ext_rsp_valid, ext_rsp_data}, 32'd0);
    endtask

    function automatic logic [15:0] rand_pos(input int cells);
        case ($urandom % 5)
            0: return 16'($urandom);
            1: return 16'($urandom % 512);
            2: return 16'(cells * 256 - 256 + int'($urandom % 512));
            3: return 16'($urandom % (cells * 256));
            default: return 16'hFF00 | 16'($urandom % 256);
        endcase
    endfunction

    int base;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 2'(a % 4);
        model_reset();
        #1 rst_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b0;
        idle(2);

        // Basic sweep at cell (10,10).
        pv_count = 0;
        base = cyc;
        ball_position_x = 16'h0A00;
        ball_position_y = 16'h0A00;
        start = 1'b1;
        step();
        idle(12);
        check("s1_pv_cycle", 32'(last_pv - base), 32'd8);
        check("s1_terrain", {22'd0, t_c, t_xp, t_yp, t_xm, t_ym},
              {22'd0, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2});

        // xminus borrows, yplus stays on the last row.
        ball_position_x = 16'h0040;
        ball_position_y = 16'h5940;
        start = 1'b1;
        step();
        idle(12);
        check("s2_xminus_oob", 32'(t_xm), 32'(OOB));
        check("s2_yplus_onmap", 32'(t_yp), 32'd0);
        ball_position_y = 16'h59C0;
        start = 1'b1;
        step();
        idle(12);
        check("s2_yplus_oob", 32'(t_yp), 32'(OOB));

        // External request held across a sweep.
        base = cyc;
        ext_req = 1'b1;
        ext_addr = 16'd100;
        ball_position_x = 16'h3000;
        ball_position_y = 16'h2000;
        start = 1'b1;
        step();
        idle(10);
        ext_req = 1'b0;
        idle(4);
        check("s3_gnt_c0", 32'(gnt_log[base]), 32'd1);
        check("s3_gnt_c6", 32'(gnt_log[base + 6]), 32'd1);
        check("s3_no_gnt_issue", 32'(gnt_log[base + 1] | gnt_log[base + 2] | gnt_log[base + 3] |
              gnt_log[base + 4] | gnt_log[base + 5]), 32'd0);

        // Starts at 0, 3 and 4; the queued sweep latches the position of cycle 8.
        pv_count = 0;
        base = cyc;
        for (int r = 0; r < 22; r++) begin
            start = (r == 0 || r == 3 || r == 4);
            if (r == 0) begin
                ball_position_x = 16'h0A00;
                ball_position_y = 16'h0A00;
            end else if (r == 8) begin
                ball_position_x = 16'h1F80;
                ball_position_y = 16'h1800;
            end else begin
                ball_position_x = rand_pos(WIDTH);
                ball_position_y = rand_pos(HEIGHT);
            end
            step();
        end
        check("s4_pv_count", 32'(pv_count), 32'd2);
        check("s4_second_pv", 32'(last_pv - base), 32'd16);
        check("s4_second_xminus", 32'(t_xm), 32'd3);

        // Asynchronous reset in the middle of a sweep.
        ball_position_x = 16'h0A00;
        ball_position_y = 16'h0A00;
        start = 1'b1;
        step();
        idle(3);
        #1 rst_in = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk_in);
        #1;
        cyc++;
        rst_in = 1'b0;
        pv_count = 0;
        idle(12);
        check("s5_no_pv_after_reset", 32'(pv_count), 32'd0);
        start = 1'b1;
        step();
        idle(10);
        check("s5_restart_pv", 32'(pv_count), 32'd1);

        // Position moves during ISSUE; the start-cycle value must be used.
        ball_position_x = 16'h2000;
        ball_position_y = 16'h1800;
        start = 1'b1;
        step();
        for (int r = 0; r < 5; r++) begin
            start = 1'b0;
            ball_position_x = rand_pos(WIDTH);
            ball_position_y = rand_pos(HEIGHT);
            step();
        end
        idle(6);
        check("s6_xminus_latched", 32'(t_xm), 32'd3);

        // Randomized traffic against random map contents.
        for (int a = 0; a < 65536; a++) mem[a] = 2'($urandom);
        idle(4);
        for (int r = 0; r < 1500; r++) begin
            start = ($urandom % 6 == 0);
            ball_position_x = rand_pos(WIDTH);
            ball_position_y = rand_pos(HEIGHT);
            if (!ext_req || last_gnt) begin
                ext_req  = ($urandom % 3 == 0);
                ext_addr = 16'($urandom);
            end
            step();
        end
        ext_req = 1'b0;
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
